// File: rtl/mmio_led_pwm.sv
// mmio_led_pwm: memory-mapped LED / RGB PWM peripheral with free-running
// microsecond and millisecond counters, occupying a 16-byte window that sits
// downstream of the processor's data-memory load/store port.
//
// Register map (offset = address[3:2]):
//   0x0 LED_CTRL  bit0 drives led
//   0x4 PWM_DUTY  [7:0] red, [15:8] green, [23:16] blue (shadow values)
//   0x8 MILLIS    read-only
//   0xC MICROS    read-only
module mmio_led_pwm #(
   parameter int unsigned CLK_HZ    = 12000000,
   parameter int unsigned PWM_BITS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        write_enable,
   input  logic        read_enable,
   input  logic [2:0]  funct3,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        led,
   output logic        red,
   output logic        green,
   output logic        blue
);

   localparam int unsigned US_DIV  = CLK_HZ / 1000000;
   localparam int unsigned PRESC_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(US_DIV - 1);
   localparam int unsigned NUM_CH  = 3;

   localparam logic [1:0] OFF_LED    = 2'd0;
   localparam logic [1:0] OFF_PWM    = 2'd1;
   localparam logic [1:0] OFF_MILLIS = 2'd2;
   localparam logic [1:0] OFF_MICROS = 2'd3;

   // ------------------------------------------------------------------
   // Address decode and byte-lane write enables
   // ------------------------------------------------------------------
   logic        hit;
   logic [1:0]  offset;
   logic [3:0]  lane_we;
   logic [31:0] lane_data;

   assign hit    = (address[31:4] == BASE_ADDR[31:4]);
   assign offset = address[3:2];

   // Steer right-aligned store data onto the byte lanes it targets; misaligned
   // half/word stores and window misses produce no lane enables at all.
   always_comb begin
      lane_we   = 4'b0000;
      lane_data = write_data;
      case (funct3)
         3'b000: begin
            lane_we[address[1:0]] = 1'b1;
            lane_data             = {4{write_data[7:0]}};
         end
         3'b001: begin
            if (!address[0]) begin
               lane_we = address[1] ? 4'b1100 : 4'b0011;
            end
            lane_data = {2{write_data[15:0]}};
         end
         default: begin
            if (address[1:0] == 2'b00) begin
               lane_we = 4'b1111;
            end
         end
      endcase
      if (!(write_enable && hit)) begin
         lane_we = 4'b0000;
      end
   end

   // Lane 3 of PWM_DUTY and the upper LED_CTRL lanes hold no storage.
   logic unused_bits;
   assign unused_bits = ^{lane_we[3], lane_data[31:24]};

   // ------------------------------------------------------------------
   // LED control
   // ------------------------------------------------------------------
   logic led_ctrl_reg;
   logic led_reg;

   // Store bit0 of lane 0 and register it once more onto the pin.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_ctrl_reg <= 1'b0;
         led_reg      <= 1'b0;
      end else begin
         if (lane_we[0] && (offset == OFF_LED)) begin
            led_ctrl_reg <= lane_data[0];
         end
         led_reg <= led_ctrl_reg;
      end
   end

   assign led = led_reg;

   // ------------------------------------------------------------------
   // Microsecond / millisecond timebase
   // ------------------------------------------------------------------
   logic [PRESC_W-1:0] presc_reg;
   logic [9:0]         us_sub_reg;
   logic [31:0]        micros_reg;
   logic [31:0]        millis_reg;
   logic               us_tick;

   assign us_tick = (presc_reg == PRESC_LAST);

   // Prescale clk down to 1 us ticks, then count 1000 ticks per millisecond.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_reg  <= '0;
         us_sub_reg <= '0;
         micros_reg <= '0;
         millis_reg <= '0;
      end else begin
         if (us_tick) begin
            presc_reg  <= '0;
            micros_reg <= micros_reg + 32'd1;
            if (us_sub_reg == 10'd999) begin
               us_sub_reg <= '0;
               millis_reg <= millis_reg + 32'd1;
            end else begin
               us_sub_reg <= us_sub_reg + 10'd1;
            end
         end else begin
            presc_reg <= presc_reg + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // PWM
   // ------------------------------------------------------------------
   logic [PWM_BITS-1:0]        pwm_cnt_reg;
   logic                       pwm_wrap;
   logic [NUM_CH*PWM_BITS-1:0] shadow_bus;
   logic [NUM_CH-1:0]          pwm_out;

   assign pwm_wrap = (pwm_cnt_reg == {PWM_BITS{1'b1}});

   // Free-running period counter shared by all channels.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_reg <= '0;
      end else begin
         pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [PWM_BITS-1:0] shadow_reg;
         logic [PWM_BITS-1:0] active_reg;
         logic                out_reg;

         // Software writes land in the shadow; the active duty only changes at
         // the period boundary so a period is never cut short or stretched.
         always_ff @(posedge clk) begin
            if (reset) begin
               shadow_reg <= '0;
               active_reg <= '0;
               out_reg    <= 1'b0;
            end else begin
               if (lane_we[gi] && (offset == OFF_PWM)) begin
                  shadow_reg <= lane_data[gi*8 +: PWM_BITS];
               end
               if (pwm_wrap) begin
                  active_reg <= shadow_reg;
               end
               out_reg <= (pwm_cnt_reg < active_reg);
            end
         end

         assign shadow_bus[gi*PWM_BITS +: PWM_BITS] = shadow_reg;
         assign pwm_out[gi] = out_reg;
      end
   endgenerate

   assign red   = pwm_out[0];
   assign green = pwm_out[1];
   assign blue  = pwm_out[2];

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   logic [31:0] read_value;
   logic [31:0] read_data_reg;

   // Full-word register value for the addressed offset; misses read zero.
   always_comb begin
      read_value = '0;
      case (offset)
         OFF_LED:    read_value = {31'b0, led_ctrl_reg};
         OFF_PWM:    read_value = {8'b0, shadow_bus};
         OFF_MILLIS: read_value = millis_reg;
         OFF_MICROS: read_value = micros_reg;
         default:    read_value = '0;
      endcase
      if (!hit) begin
         read_value = '0;
      end
   end

   // Capture on the load strobe and hold until the next load; a store in the
   // same cycle is not visible here because register state updates afterward.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data_reg <= '0;
      end else if (read_enable) begin
         read_data_reg <= read_value;
      end
   end

   assign read_data = read_data_reg;

endmodule

// File: doc/mmio_led_pwm.md
Name: mmio_led_pwm

Overview:
Memory-mapped output peripheral that sits downstream of the processor's data-memory interface and consumes its load/store traffic in a fixed 16-byte address window. It holds an LED control register and three 8-bit PWM duty registers that drive the led, red, green and blue board outputs. It also provides free-running millisecond and microsecond counters that software can read. It replaces direct LED wiring in top, so test programs can produce observable outputs with sw/sb instructions.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz; must be a multiple of 1000000.
PWM_BITS, 8, PWM counter and duty width; fixed at 8 for this revision.
BASE_ADDR, 32'hFFFF_FFF0, window base; only address[31:4] is compared.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  32  byte address from the processor ALU result
write_enable  input  1  store strobe, one cycle per store
read_enable  input  1  load strobe, one cycle per load
funct3  input  3  store/load size: 000 = byte, 001 = half, 010 = word; others are treated as word
write_data  input  32  store data, right-aligned as the processor emits it
read_data  output  32  registered load data
led  output  1  user LED, active-high
red  output  1  red PWM output, active-high
green  output  1  green PWM output, active-high
blue  output  1  blue PWM output, active-high

Behaviour:
- Hit condition: address[31:4] == BASE_ADDR[31:4]. Register offset = address[3:2]; byte lane = address[1:0].
- Register map:
  - 0x0 LED_CTRL (R/W): only bit0 is stored; other bits read 0.
  - 0x4 PWM_DUTY (R/W): [7:0] red, [15:8] green, [23:16] blue; [31:24] read 0.
  - 0x8 MILLIS (RO).
  - 0xC MICROS (RO).
- Writes:
  - Occur on the clk edge where write_enable = 1 and the address hits.
  - Byte store updates only lane address[1:0], using write_data[7:0].
  - Half store with address[0] = 1 is dropped. Otherwise it updates lanes {address[1],0} and {address[1],1}.
  - Word store with address[1:0] != 0 is dropped.
  - Stores to MILLIS/MICROS and stores that miss the window have no effect.
- Reads:
  - One-cycle latency. read_data is registered on the edge where read_enable = 1, and holds that value until the next read.
  - Returns the full 32-bit register with no lane shifting (the processor extracts lanes).
  - A miss returns 0.
  - Simultaneous read and write to the same register returns the old value.
- Timebase:
  - A prescaler counts 0 to CLK_HZ/1000000 - 1. On wrap it emits a 1-cycle us_tick.
  - MICROS increments by 1 on each us_tick.
  - A sub-counter counts 0 to 999 us_ticks. On its wrap, MILLIS increments.
  - Both counters wrap 0xFFFFFFFF to 0.
- PWM:
  - An 8-bit pwm_cnt increments every clk and wraps 255 to 0.
  - Each channel has an active duty register and a shadow register. Writes go to the shadow. Shadow copies to active on the edge where pwm_cnt wraps 255 to 0.
  - Output = (pwm_cnt < active_duty), registered.
  - Duty 0 gives a constant low output; duty 255 gives high for 255 of every 256 cycles.
  - Reads of PWM_DUTY return the shadow values.
- led output = LED_CTRL[0] registered; it changes on the cycle after the store edge.
- Reset (synchronous):
  - All registers, shadows, counters and prescalers clear to 0. read_data = 0. led/red/green/blue = 0.
  - Reset asserted mid-PWM-period or mid-prescale restarts everything from 0 on the next edge. Strobes during reset are ignored.

Test Plan:
- Reset, then sw 0x00000001 to 0xFFFFFFF0 -> led = 1 one cycle after the store edge. Then sb 0x00 to 0xFFFFFFF0 -> led = 0. Read back -> read_data = 0x00000000.
- Word store 0x00FF8000 to 0xFFFFFFF4 -> after the next pwm_cnt wrap, per 256-cycle period: red high 0 cycles, green high 128 cycles, blue high 255 cycles.
- Store at mid-period (pwm_cnt = 100) changing red 0x40 -> 0xC0 -> red keeps 64 high cycles until the wrap, then 192. A read of 0xFFFFFFF4 immediately returns 0x000000C0 in the red byte.
- CLK_HZ = 2000000: after reset plus 2000 cycles -> MICROS = 1000 and MILLIS = 1. Then sw 0x12345678 to 0xFFFFFFF8 -> MILLIS unchanged.
- sh 0xBEEF at 0xFFFFFFF5 (misaligned) and sw at 0xFFFFFFF6 -> both dropped, PWM_DUTY unchanged. sb 0x7F at 0xFFFFFFF6 -> blue = 0x7F only.
- Load from 0x00000010 (window miss) -> read_data = 0. Reset asserted while MICROS = 37 -> MICROS = 0, all outputs 0 on the next edge.
